// File: rtl/full_adder.sv
// full_adder: registered ripple-carry adder, {c_out,s} = a + b + c_in.
// Define FULL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module full_adder #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
`ifdef FULL_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic             out_valid
);

   logic [WIDTH-1:0] sum;
   logic             carry;
   logic [WIDTH-1:0] s_q, s_d;
   logic             c_out_q, c_out_d;
   logic             out_valid_q, out_valid_d;
`ifdef FULL_ADDER_OVF_EN
   logic             carry_prev;
   logic             ovf_q, ovf_d;
`endif

   // Ripple chain of 1-bit cells; carry_prev ends as c_(WIDTH-1).
   always_comb begin
      sum   = '0;
      carry = c_in;
`ifdef FULL_ADDER_OVF_EN
      carry_prev = c_in;
`endif
      for (int i = 0; i < WIDTH; i++) begin
`ifdef FULL_ADDER_OVF_EN
         carry_prev = carry;
`endif
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
   end

   always_comb begin
      s_d         = s_q;
      c_out_d     = c_out_q;
      out_valid_d = in_valid;
`ifdef FULL_ADDER_OVF_EN
      ovf_d       = ovf_q;
`endif
      if (in_valid) begin
         s_d     = sum;
         c_out_d = carry;
`ifdef FULL_ADDER_OVF_EN
         ovf_d   = carry ^ carry_prev;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q         <= '0;
         c_out_q     <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         s_q         <= s_d;
         c_out_q     <= c_out_d;
         out_valid_q <= out_valid_d;
`ifdef FULL_ADDER_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign s         = s_q;
   assign c_out     = c_out_q;
   assign out_valid = out_valid_q;
`ifdef FULL_ADDER_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: scoreboard bench for full_adder at WIDTH 1, 4 and 8.
// Builds with or without FULL_ADDER_OVF_EN.
module tb_full_adder;

   typedef struct packed {
      logic        v;
      logic [63:0] s;
      logic        c;
      logic        o;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       v1 = 0, a1 = 0, b1 = 0, c1 = 0;
   logic       v4 = 0, c4 = 0;
   logic [3:0] a4 = 0, b4 = 0;
   logic       v8 = 0, c8 = 0;
   logic [7:0] a8 = 0, b8 = 0;

   logic       s1, co1, ov1, o1;
   logic [3:0] s4;
   logic       co4, ov4, o4;
   logic [7:0] s8;
   logic       co8, ov8, o8;

   int checks = 0;
   int failures = 0;

   exp_t q1[$], q4[$], q8[$];
   exp_t st1 = '0, st4 = '0, st8 = '0;

   always #5 clk = ~clk;

   full_adder #(.WIDTH(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1),
      .a(a1), .b(b1), .c_in(c1), .s(s1), .c_out(co1),
`ifdef FULL_ADDER_OVF_EN
      .ovf(ov1),
`endif
      .out_valid(o1)
   );

   full_adder #(.WIDTH(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4),
      .a(a4), .b(b4), .c_in(c4), .s(s4), .c_out(co4),
`ifdef FULL_ADDER_OVF_EN
      .ovf(ov4),
`endif
      .out_valid(o4)
   );

   full_adder #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8),
      .a(a8), .b(b8), .c_in(c8), .s(s8), .c_out(co8),
`ifdef FULL_ADDER_OVF_EN
      .ovf(ov8),
`endif
      .out_valid(o8)
   );

`ifndef FULL_ADDER_OVF_EN
   assign ov1 = 1'b0;
   assign ov4 = 1'b0;
   assign ov8 = 1'b0;
`endif

   task automatic check(input string tag, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Reference: plain integer add, signed overflow from operand/result signs.
   function automatic exp_t next_state(input exp_t cur, input int w,
                                       input logic v, input logic [63:0] a,
                                       input logic [63:0] b, input logic c);
      exp_t        r;
      logic [64:0] tot;
      logic [63:0] m;
      m = (64'd1 << w) - 64'd1;
      r = cur;
      r.v = v;
      if (v) begin
         tot = {1'b0, a & m} + {1'b0, b & m} + {64'd0, c};
         r.s = tot[63:0] & m;
         r.c = tot[w];
         r.o = (a[w-1] == b[w-1]) && (r.s[w-1] != a[w-1]);
      end
      return r;
   endfunction

   function automatic exp_t advance(input exp_t cur, input int w,
                                    input logic v, input logic [63:0] a,
                                    input logic [63:0] b, input logic c);
      if (!rst_n) return '0;
      return next_state(cur, w, v, a, b, c);
   endfunction

   task automatic compare(input string n, input exp_t e, input logic ov,
                          input logic [63:0] s, input logic c, input logic o);
      check({n, "_valid"}, {63'd0, ov}, {63'd0, e.v});
      if (e.v || !rst_n) begin
         check({n, "_s"}, s, e.s);
         check({n, "_cout"}, {63'd0, c}, {63'd0, e.c});
`ifdef FULL_ADDER_OVF_EN
         check({n, "_ovf"}, {63'd0, o}, {63'd0, e.o});
`endif
      end
   endtask

   // Push expectations for the current inputs, clock once, pop and compare.
   task automatic step();
      exp_t e;
      st1 = advance(st1, 1, v1, {63'd0, a1}, {63'd0, b1}, c1);
      st4 = advance(st4, 4, v4, {60'd0, a4}, {60'd0, b4}, c4);
      st8 = advance(st8, 8, v8, {56'd0, a8}, {56'd0, b8}, c8);
      q1.push_back(st1);
      q4.push_back(st4);
      q8.push_back(st8);
      @(posedge clk);
      #1;
      e = q1.pop_front();
      compare("w1", e, o1, {63'd0, s1}, co1, ov1);
      e = q4.pop_front();
      compare("w4", e, o4, {60'd0, s4}, co4, ov4);
      e = q8.pop_front();
      compare("w8", e, o8, {56'd0, s8}, co8, ov8);
   endtask

   task automatic idle_all();
      v1 = 0;
      v4 = 0;
      v8 = 0;
   endtask

   initial begin
      logic [2:0] pat;
      #3;
      check("rst_w4_s", {60'd0, s4}, 64'd0);
      check("rst_w4_valid", {63'd0, o4}, 64'd0);
      check("rst_w8_cout", {63'd0, co8}, 64'd0);
      #4 rst_n = 1'b1;

      // WIDTH=1 exhaustive
      for (int i = 0; i < 8; i++) begin
         pat = 3'(i);
         v1 = 1;
         {a1, b1, c1} = pat;
         step();
      end
      idle_all();
      step();

      // WIDTH=4 wrap cases
      v4 = 1;
      a4 = 15; b4 = 0;  c4 = 1; step();
      a4 = 15; b4 = 15; c4 = 1; step();
      a4 = 7;  b4 = 8;  c4 = 0; step();

      // Hold while invalid
      a4 = 3; b4 = 4; c4 = 0; step();
      v4 = 0;
      for (int i = 0; i < 3; i++) begin
         a4 = 4'(i * 5 + 9);
         b4 = 4'(~i);
         c4 = 1'(i);
         step();
      end
      check("hold_w4_s", {60'd0, s4}, 64'd7);

      // Asynchronous reset between edges
      v4 = 1; a4 = 4; b4 = 5; c4 = 0;
      step();
      #2 rst_n = 1'b0;
      #1;
      check("arst_w4_s", {60'd0, s4}, 64'd0);
      check("arst_w4_cout", {63'd0, co4}, 64'd0);
      check("arst_w4_valid", {63'd0, o4}, 64'd0);
      a4 = 15; b4 = 15; c4 = 1;
      step();
      #3 rst_n = 1'b1;
      a4 = 2; b4 = 3; c4 = 0;
      step();
      v4 = 0;
      step();

      // WIDTH=8 back-to-back random
      v8 = 1;
      for (int i = 0; i < 16; i++) begin
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         c8 = 1'($urandom);
         if (i == 0) begin
            a8 = 8'hff; b8 = 8'hff; c8 = 1;
         end
         step();
      end
      v8 = 0;

      // Signed-overflow cases
      v4 = 1;
      a4 = 7;  b4 = 1; c4 = 0; step();
      a4 = 8;  b4 = 8; c4 = 0; step();
      a4 = 15; b4 = 1; c4 = 0; step();
      a4 = 7;  b4 = 0; c4 = 1; step();
      idle_all();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
